// File: rtl/rr_arbiter8_pkg.sv
// rtl/rr_arbiter8_pkg.sv - shared types and sizes for the 8-way round-robin arbiter
package rr_arbiter8_pkg;
    localparam int N_REQ = 8;
    localparam int ID_W  = 3;

    typedef logic [ID_W-1:0]  id_t;
    typedef logic [N_REQ-1:0] vec_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;
endpackage

// File: rtl/rr_arbiter8_if.sv
// rtl/rr_arbiter8_if.sv - request/grant bundle between requesters and the arbiter
interface rr_arbiter8_if;
    import rr_arbiter8_pkg::*;

    logic en;
    vec_t req;
    logic done;
    vec_t gnt;
    id_t  gnt_id;
    logic gnt_valid;
    logic timeout;

    modport master (
        output en, req, done,
        input  gnt, gnt_id, gnt_valid, timeout
    );

    modport slave (
        input  en, req, done,
        output gnt, gnt_id, gnt_valid, timeout
    );
endinterface

// File: rtl/rr_arbiter8_prio_enc8.sv
// rtl/rr_arbiter8_prio_enc8.sv - combinational 8-bit highest-set-bit priority encoder
module prio_enc8
    import rr_arbiter8_pkg::*;
(
    input  vec_t vec,
    output id_t  idx,
    output logic valid
);
    always_comb begin
        idx = '0;
        // Ascending scan so the highest set bit is the last to write idx.
        for (int i = 0; i < N_REQ; i++) begin
            if (vec[i]) begin
                idx = ID_W'(i);
            end
        end
        valid = |vec;
    end
endmodule

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - 8-way round-robin arbiter with idle turnaround and hold limit
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int MAX_HOLD = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_arbiter8_if.slave bus
);
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

    state_e     state_q, state_d;
    vec_t       gnt_q, gnt_d;
    id_t        gnt_id_q, gnt_id_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic       timeout_q, timeout_d;
    id_t        last_id_q, last_id_d;
    logic [7:0] cnt_q, cnt_d;

    vec_t mask;
    vec_t masked;
    id_t  m_idx, r_idx;
    logic m_valid, r_valid;
    id_t  winner;
    logic holder_req;
    logic at_limit;

    // Lower-index requesters than the last winner get first pick.
    assign mask   = (vec_t'(1) << last_id_q) - vec_t'(1);
    assign masked = bus.req & mask;

    prio_enc8 u_enc_masked (.vec(masked),  .idx(m_idx), .valid(m_valid));
    prio_enc8 u_enc_raw    (.vec(bus.req), .idx(r_idx), .valid(r_valid));

    assign winner     = m_valid ? m_idx : r_idx;
    assign holder_req = bus.req[gnt_id_q];
    assign at_limit   = (cnt_q == HOLD_LIM);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        last_id_d   = last_id_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                gnt_d       = '0;
                gnt_id_d    = '0;
                gnt_valid_d = 1'b0;
                if (bus.en && r_valid) begin
                    state_d     = BUSY;
                    gnt_d       = vec_t'(1) << winner;
                    gnt_id_d    = winner;
                    gnt_valid_d = 1'b1;
                    last_id_d   = winner;
                    cnt_d       = '0;
                end
            end
            BUSY: begin
                if (bus.done || !holder_req || at_limit) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_id_d    = '0;
                    gnt_valid_d = 1'b0;
                    // Only a pure hold-limit revocation counts as a timeout.
                    timeout_d   = at_limit && !bus.done && holder_req;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            last_id_q   <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            last_id_q   <= last_id_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.timeout   = timeout_q;
endmodule
